// File: rtl/fetch_issue_ctrl_if.sv
// Purpose: bundles the icache fetch handshake, decoder hook, downstream occupancy,
//          dispatch bundle and redirect signals of fetch_issue_ctrl.
// Ports:   master = the fetch/issue block, slave = its environment (icache, decoder, backend).
interface fetch_issue_ctrl_if;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_valid;
    logic [31:0] ic_inst;
    logic [31:0] dec_inst;
    logic        dec_is_ls;
    logic        rob_full;
    logic        rs_full;
    logic        lsb_full;
    logic        issue_valid;
    logic [31:0] issue_inst;
    logic [31:0] issue_pc;
    logic        issue_to_lsb;
    logic        flush;
    logic [31:0] flush_pc;

    modport master (
        output ic_req, ic_addr, dec_inst, issue_valid, issue_inst, issue_pc, issue_to_lsb,
        input  ic_valid, ic_inst, dec_is_ls, rob_full, rs_full, lsb_full, flush, flush_pc
    );

    modport slave (
        input  ic_req, ic_addr, dec_inst, issue_valid, issue_inst, issue_pc, issue_to_lsb,
        output ic_valid, ic_inst, dec_is_ls, rob_full, rs_full, lsb_full, flush, flush_pc
    );
endinterface

// File: rtl/fetch_issue_ctrl.sv
// Purpose: in-order fetch (static pc+4) into a QDEPTH-entry instruction queue, issue one per cycle.
// Latency: ic_valid edge pushes, earliest issue_valid on the following edge; dispatch bundle registered.
// Backpressure: no fetch while queue full; issue stalls on rob_full and rs_full/lsb_full; rdy_in=0 freezes.
// Ports: clk_in/rst_in (sync, active-high), rdy_in, bus (master side of fetch_issue_ctrl_if).
module fetch_issue_ctrl #(
    parameter int QDEPTH = 4   // power of two, >= 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    fetch_issue_ctrl_if.master  bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   pc_q   [QDEPTH];
    logic [31:0]   inst_q [QDEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;

    logic        ic_req;
    logic [31:0] ic_addr;
    logic        issue_valid;
    logic [31:0] issue_inst;
    logic [31:0] issue_pc;
    logic        issue_to_lsb;

    logic can_issue;
    logic do_pop;
    logic do_push;

    // Decoder looks at the head word combinationally and returns dec_is_ls the same cycle.
    assign bus.dec_inst = inst_q[head];

    assign can_issue = (count != '0) && !bus.rob_full &&
                       (bus.dec_is_ls ? !bus.lsb_full : !bus.rs_full);
    assign do_pop    = can_issue && rdy_in && !bus.flush;
    // A full queue only takes the word if the head leaves on the same edge.
    assign do_push   = (state == WAIT) && bus.ic_valid && rdy_in && !bus.flush &&
                       ((count != QFULL) || do_pop);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= IDLE;
            pc           <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            ic_req       <= 1'b0;
            ic_addr      <= '0;
            issue_valid  <= 1'b0;
            issue_inst   <= '0;
            issue_pc     <= '0;
            issue_to_lsb <= 1'b0;
        end else if (bus.flush) begin
            // Redirect wins over everything, including a stalled rdy_in.
            pc          <= bus.flush_pc;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            issue_valid <= 1'b0;
            ic_req      <= 1'b0;
            case (state)
                // The in-flight response belongs to the old path: swallow it in DROP,
                // or discard it right away if it lands on the flush edge.
                WAIT:    state <= bus.ic_valid ? IDLE : DROP;
                DROP:    state <= bus.ic_valid ? IDLE : DROP;
                default: state <= IDLE;
            endcase
        end else if (!rdy_in) begin
            issue_valid <= 1'b0;
        end else begin
            issue_valid <= can_issue;
            if (can_issue) begin
                issue_inst   <= inst_q[head];
                issue_pc     <= pc_q[head];
                issue_to_lsb <= bus.dec_is_ls;
                head         <= head + AW'(1);
            end

            if (do_push) begin
                pc_q[tail]   <= pc;
                inst_q[tail] <= bus.ic_inst;
                tail         <= tail + AW'(1);
            end

            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (count < QFULL) begin
                        ic_req  <= 1'b1;
                        ic_addr <= pc;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // ic_req/ic_addr stay put until the response is taken.
                    if (do_push) begin
                        ic_req <= 1'b0;
                        pc     <= pc + 32'd4;
                        state  <= IDLE;
                    end
                end
                DROP: begin
                    if (bus.ic_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ic_req       = ic_req;
    assign bus.ic_addr      = ic_addr;
    assign bus.issue_valid  = issue_valid;
    assign bus.issue_inst   = issue_inst;
    assign bus.issue_pc     = issue_pc;
    assign bus.issue_to_lsb = issue_to_lsb;
endmodule

// File: tb/tb_fetch_issue_ctrl.sv
module tb_fetch_issue_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic rdy;

    always #5 clk = ~clk;

    fetch_issue_ctrl_if bus();

    fetch_issue_ctrl #(.QDEPTH(4)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus.master)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ls;
    } exp_t;

    exp_t sb[$];
    int   total    = 0;
    int   bad      = 0;
    int   n_issued = 0;
    int   n0;

    // Reference decoder: RV32 loads and stores.
    function automatic logic is_ls(input logic [31:0] w);
        return (w[6:0] == 7'b0000011) || (w[6:0] == 7'b0100011);
    endfunction

    assign bus.dec_is_ls = is_ls(bus.dec_inst);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1ns after the edge and every issue is scored.
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        if (bus.issue_valid === 1'b1) begin
            n_issued++;
            if (sb.size() == 0) begin
                chk("issue_unexpected", 32'(bus.issue_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("issue_pc", bus.issue_pc, e.pc);
                chk("issue_inst", bus.issue_inst, e.inst);
                chk("issue_to_lsb", 32'(bus.issue_to_lsb), 32'(e.ls));
            end
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        rdy          = 1'b1;
        bus.ic_valid = 1'b0;
        bus.ic_inst  = '0;
        bus.rob_full = 1'b0;
        bus.rs_full  = 1'b0;
        bus.lsb_full = 1'b0;
        bus.flush    = 1'b0;
        bus.flush_pc = '0;
        cyc();
        cyc();
        sb.delete();
        rst = 1'b0;
    endtask

    task automatic wait_req(input logic [31:0] addr);
        int n = 0;
        while (bus.ic_req !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk("ic_req_seen", 32'(bus.ic_req), 32'd1);
        chk("ic_addr", bus.ic_addr, addr);
    endtask

    // Icache model: answer the pending request lat edges after it was raised.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] inst,
                         input int lat, input bit accept);
        wait_req(addr);
        repeat (lat - 1) cyc();
        bus.ic_valid = 1'b1;
        bus.ic_inst  = inst;
        if (accept) sb.push_back({addr, inst, is_ls(inst)});
        cyc();
        bus.ic_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst          = 1'b1;
        rdy          = 1'b1;
        bus.ic_valid = 1'b0;
        bus.ic_inst  = '0;
        bus.rob_full = 1'b0;
        bus.rs_full  = 1'b0;
        bus.lsb_full = 1'b0;
        bus.flush    = 1'b0;
        bus.flush_pc = '0;
        cyc();
        cyc();
        chk("rst_ic_req", 32'(bus.ic_req), 32'd0);
        chk("rst_ic_addr", bus.ic_addr, 32'd0);
        chk("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("rst_issue_inst", bus.issue_inst, 32'd0);
        chk("rst_issue_pc", bus.issue_pc, 32'd0);
        chk("rst_issue_to_lsb", 32'(bus.issue_to_lsb), 32'd0);
        rst = 1'b0;

        // First fetch with a 2-cycle icache, issue on the next edge after the push
        fetch(32'h0, 32'h00500093, 2, 1'b1);
        n0 = n_issued;
        cyc();
        chk("first_issue_latency", 32'(n_issued), 32'(n0 + 1));

        // rob_full: queue fills with 4 entries, fetching stops, then drains back-to-back
        do_reset();
        bus.rob_full = 1'b1;
        for (int i = 0; i < 4; i++)
            fetch(32'(i * 4), 32'h00100093 + 32'(i << 20), 1, 1'b1);
        n0 = n_issued;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("full_no_req", 32'(bus.ic_req), 32'd0);
        end
        chk("full_no_issue", 32'(n_issued), 32'(n0));
        bus.rob_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("drain_consecutive", 32'(bus.issue_valid), 32'd1);
        end
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);

        // Load at head blocked by lsb_full, released to the LSB
        do_reset();
        bus.lsb_full = 1'b1;
        fetch(32'h0, 32'h00002083, 1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("ls_blocked", 32'(bus.issue_valid), 32'd0);
        end
        bus.lsb_full = 1'b0;
        cyc();
        chk("ls_issue", 32'(bus.issue_valid), 32'd1);
        chk("ls_to_lsb", 32'(bus.issue_to_lsb), 32'd1);

        // Flush while waiting: the late word is dropped, refetch from flush_pc
        do_reset();
        wait_req(32'h0);
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h100;
        cyc();
        bus.flush = 1'b0;
        chk("drop_no_req", 32'(bus.ic_req), 32'd0);
        cyc();
        chk("drop_no_req2", 32'(bus.ic_req), 32'd0);
        bus.ic_valid = 1'b1;
        bus.ic_inst  = 32'h00700093;
        n0 = n_issued;
        cyc();
        bus.ic_valid = 1'b0;
        fetch(32'h100, 32'h00900093, 1, 1'b1);
        cyc();
        cyc();
        chk("drop_issue_count", 32'(n_issued), 32'(n0 + 1));
        chk("drop_sb_empty", 32'(sb.size()), 32'd0);

        // Flush coinciding with ic_valid, 3 entries queued
        do_reset();
        bus.rob_full = 1'b1;
        for (int i = 0; i < 3; i++)
            fetch(32'(i * 4), 32'h00200113 + 32'(i << 20), 1, 1'b1);
        wait_req(32'hC);
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h200;
        bus.ic_valid = 1'b1;
        bus.ic_inst  = 32'h00300193;
        bus.rob_full = 1'b0;
        sb.delete();
        n0 = n_issued;
        cyc();
        bus.flush    = 1'b0;
        bus.ic_valid = 1'b0;
        chk("flush_no_issue", 32'(bus.issue_valid), 32'd0);
        cyc();
        cyc();
        chk("flush_queue_empty", 32'(n_issued), 32'(n0));
        fetch(32'h200, 32'h00400213, 1, 1'b1);
        cyc();
        cyc();
        chk("flush_refetch_issue", 32'(n_issued), 32'(n0 + 1));

        // Push and pop on the same edge: count holds, new word issues after the older three
        do_reset();
        bus.rob_full = 1'b1;
        for (int i = 0; i < 3; i++)
            fetch(32'(i * 4), 32'h00500293 + 32'(i << 20), 1, 1'b1);
        wait_req(32'hC);
        bus.ic_valid = 1'b1;
        bus.ic_inst  = 32'h00023303;
        sb.push_back({32'hC, 32'h00023303, 1'b1});
        bus.rob_full = 1'b0;
        cyc();
        bus.ic_valid = 1'b0;
        chk("pp_issue0", 32'(bus.issue_valid), 32'd1);
        for (int i = 1; i < 4; i++) begin
            cyc();
            chk("pp_issue_run", 32'(bus.issue_valid), 32'd1);
        end
        chk("pp_sb_empty", 32'(sb.size()), 32'd0);

        // rdy_in low freezes the block and suppresses issue
        do_reset();
        fetch(32'h0, 32'h00600313, 1, 1'b1);
        rdy = 1'b0;
        n0 = n_issued;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("rdy_hold_no_issue", 32'(bus.issue_valid), 32'd0);
            chk("rdy_hold_no_req", 32'(bus.ic_req), 32'd0);
        end
        rdy = 1'b1;
        cyc();
        chk("rdy_resume_issue", 32'(n_issued), 32'(n0 + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
